// File: rtl/ptosda_pkg.sv
// Shared types and helpers for the ptosda_frame serial framer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// state_t is one-hot; IDLE is also the reset state.
// frame_cycles() gives the accept-edge to data_ready-high distance in sclk
// cycles for a given configuration.
package ptosda_pkg;

   typedef enum logic [4:0] {
      IDLE   = 5'b00001,
      START  = 5'b00010,
      DATA   = 5'b00100,
      PARITY = 5'b01000,
      STOP   = 5'b10000
   } state_t;

   // START (1 half) + data bits (2 halves each) + STOP (2 halves)
   // + bus-free time in IDLE (1 half), plus one bit-time when parity is on.
   function automatic int frame_cycles(input int data_w, input int half_div,
                                       input bit parity_en);
      return half_div * (2 * data_w + 4) + (parity_en ? 2 * half_div : 0);
   endfunction

endpackage

// File: rtl/ptosda_frame_if.sv
// Word handshake and serial line bundle between a parallel source and ptosda_frame.
// Latency: n/a (wires only).
// Backpressure: data is offered with data_valid and taken when data_ready is high.
//
// master: parallel source side (drives data/data_valid, observes the line).
// slave : framer side (drives data_ready, scl, sda, busy, frame_done).
interface ptosda_frame_if #(
   parameter int DATA_W = 4
);
   logic [DATA_W-1:0] data;
   logic              data_valid;
   logic              data_ready;
   logic              scl;
   logic              sda;
   logic              busy;
   logic              frame_done;

   modport master (
      output data, data_valid,
      input  data_ready, scl, sda, busy, frame_done
   );

   modport slave (
      input  data, data_valid,
      output data_ready, scl, sda, busy, frame_done
   );
endinterface

// File: rtl/ptosda_phase_tick.sv
// Half-period timer: pulses tick on the last sclk cycle of every scl half-period.
// Latency: tick is high HALF_DIV cycles after clr drops (combinational from the counter).
// Backpressure: none; clr holds the counter at 0 while the framer waits for a word.
//
// Ports: sclk (clock), rst (sync active-high reset), clr (hold counter at 0),
//        tick (one-cycle pulse when hc == HALF_DIV-1).
module ptosda_phase_tick #(
   parameter int HALF_DIV = 1
) (
   input  logic sclk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int              HC_W    = $clog2(HALF_DIV + 1);
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_DIV - 1);

   logic [HC_W-1:0] hc;

   always_ff @(posedge sclk) begin
      if (rst || clr) begin
         hc <= '0;
      end else if (hc == HC_LAST) begin
         hc <= '0;
      end else begin
         hc <= hc + HC_W'(1);
      end
   end

   // Suppressed while clr is high so the first phase after acceptance is full length.
   assign tick = !clr && (hc == HC_LAST);

endmodule

// File: rtl/ptosda_frame.sv
// Parallel-to-serial framer: one DATA_W word -> START, data bits, optional parity, STOP on scl/sda.
// Latency: accept edge to data_ready high = HALF_DIV*(2*DATA_W+4) (+2*HALF_DIV with parity).
// Backpressure: data_ready drops at acceptance and returns after the frame and bus-free time.
//
// Ports: sclk (clock), rst (sync active-high reset), bus (ptosda_frame_if slave:
//        data/data_valid/data_ready handshake, scl/sda line, busy, frame_done).
// All outputs come straight from flops.
module ptosda_frame
   import ptosda_pkg::*;
#(
   parameter int DATA_W     = 4,
   parameter int HALF_DIV   = 1,
   parameter int LSB_FIRST  = 0,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic            sclk,
   input  logic            rst,
   ptosda_frame_if.slave   bus
);
   localparam int              BC_W         = $clog2(DATA_W + 1);
   localparam logic [BC_W-1:0] BC_LAST      = BC_W'(DATA_W);
   localparam int              FRAME_CYCLES = frame_cycles(DATA_W, HALF_DIV, PARITY_EN != 0);

   state_t            state;
   logic              high_q;     // 0: low half of a bit slot, 1: high half
   logic [DATA_W-1:0] shreg;      // next bit to send is always the MSB
   logic              par_q;
   logic [BC_W-1:0]   bc;         // data bits already placed on sda
   logic              scl_q;
   logic              sda_q;
   logic              rdy_q;
   logic              busy_q;
   logic              done_q;

   logic              tick;
   logic              clr;
   logic [DATA_W-1:0] data_ord;
   logic              par_in;

   // Reversing the word for LSB-first lets the shifter always send from the top.
   always_comb begin
      data_ord = bus.data;
      if (LSB_FIRST != 0) begin
         for (int i = 0; i < DATA_W; i++) begin
            data_ord[i] = bus.data[DATA_W-1-i];
         end
      end
   end

   assign par_in = (^bus.data) ^ (PARITY_ODD != 0);

   // The half-period timer idles at 0 while waiting for a word, so the START
   // phase begins with a fresh count on the accept edge.
   assign clr = (state == IDLE) && rdy_q;

   ptosda_phase_tick #(
      .HALF_DIV (HALF_DIV)
   ) u_tick (
      .sclk (sclk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   always_ff @(posedge sclk) begin
      if (rst) begin
         state  <= IDLE;
         high_q <= 1'b0;
         shreg  <= '0;
         par_q  <= 1'b0;
         bc     <= '0;
         scl_q  <= 1'b1;
         sda_q  <= 1'b1;
         rdy_q  <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!rdy_q) begin
                  // Bus-free time after STOP before the next word is taken.
                  if (tick) begin
                     rdy_q <= 1'b1;
                  end
               end else if (bus.data_valid) begin
                  state  <= START;
                  sda_q  <= 1'b0;        // sda falls with scl still high
                  rdy_q  <= 1'b0;
                  busy_q <= 1'b1;
                  shreg  <= data_ord;
                  par_q  <= par_in;
                  bc     <= '0;
               end
            end

            START: begin
               if (tick) begin
                  state  <= DATA;
                  high_q <= 1'b0;
                  scl_q  <= 1'b0;
                  sda_q  <= shreg[DATA_W-1];
                  shreg  <= shreg << 1;
                  bc     <= bc + BC_W'(1);
               end
            end

            DATA: begin
               if (tick) begin
                  if (!high_q) begin
                     high_q <= 1'b1;
                     scl_q  <= 1'b1;
                  end else if (bc == BC_LAST) begin
                     high_q <= 1'b0;
                     scl_q  <= 1'b0;
                     if (PARITY_EN != 0) begin
                        state <= PARITY;
                        sda_q <= par_q;
                     end else begin
                        state <= STOP;
                        sda_q <= 1'b0;
                     end
                  end else begin
                     // sda only moves together with the scl fall.
                     high_q <= 1'b0;
                     scl_q  <= 1'b0;
                     sda_q  <= shreg[DATA_W-1];
                     shreg  <= shreg << 1;
                     bc     <= bc + BC_W'(1);
                  end
               end
            end

            PARITY: begin
               if (tick) begin
                  if (!high_q) begin
                     high_q <= 1'b1;
                     scl_q  <= 1'b1;
                  end else begin
                     state  <= STOP;
                     high_q <= 1'b0;
                     scl_q  <= 1'b0;
                     sda_q  <= 1'b0;
                  end
               end
            end

            STOP: begin
               if (tick) begin
                  if (!high_q) begin
                     high_q <= 1'b1;
                     scl_q  <= 1'b1;
                  end else begin
                     // sda rises with scl high; data_ready waits for bus-free time.
                     state  <= IDLE;
                     high_q <= 1'b0;
                     sda_q  <= 1'b1;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.data_ready = rdy_q;
   assign bus.scl        = scl_q;
   assign bus.sda        = sda_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;

   // Cycles since data_ready last dropped; only observed by the checks below.
   logic [15:0] len_cnt;

   always_ff @(posedge sclk) begin
      if (rst || rdy_q) begin
         len_cnt <= '0;
      end else begin
         len_cnt <= len_cnt + 16'd1;
      end
   end

   // A complete frame always takes exactly FRAME_CYCLES from accept to ready.
   a_frame_len: assert property (@(posedge sclk) disable iff (rst)
      ($rose(rdy_q) && (len_cnt != 16'd0)) |-> (len_cnt == 16'(FRAME_CYCLES)));

   // While a bit is on the line, sda is frozen for the whole scl-high half.
   a_sda_stable: assert property (@(posedge sclk) disable iff (rst)
      (!$past(rst) && $past(scl_q) && scl_q &&
       ($past(state) == DATA || $past(state) == PARITY)) |-> (sda_q == $past(sda_q)));

endmodule
